// File: rtl/udp_tx_tile_pkg.sv
// Shared widths, flit layouts and FSM encoding for the UDP TX tile NoC input deserializer.
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif
`ifndef IP_ADDR_W
`define IP_ADDR_W 32
`endif
`ifndef TOT_LEN_W
`define TOT_LEN_W 16
`endif
`ifndef PROTOCOL_W
`define PROTOCOL_W 8
`endif
`ifndef MAC_INTERFACE_W
`define MAC_INTERFACE_W 512
`endif
`ifndef MAC_PADBYTES_W
`define MAC_PADBYTES_W 6
`endif

package udp_tx_tile_pkg;
  localparam int NOC_W      = `NOC_DATA_WIDTH;
  localparam int IP_W       = `IP_ADDR_W;
  localparam int LEN_W      = `TOT_LEN_W;
  localparam int PROTO_W    = `PROTOCOL_W;
  localparam int MAC_W      = `MAC_INTERFACE_W;
  localparam int PAD_W      = `MAC_PADBYTES_W;
  localparam int TS_W       = 64;
  localparam int BEAT_BYTES = 64;
  localparam int META_USED  = TS_W + PROTO_W + LEN_W + 2 * IP_W;

  typedef struct packed {
    logic [TS_W-1:0] ts;
  } tracker_stats_struct;

  typedef enum logic [1:0] {
    WAIT_HDR,
    WAIT_META,
    HDR_OUT,
    DATA_OUT
  } deser_state_e;

  // Routing fields sit in the low bits of the header flit.
  typedef struct packed {
    logic [NOC_W-33:0] rsvd;
    logic [15:0]       msg_len;
    logic [7:0]        dst_y;
    logic [7:0]        dst_x;
  } noc_hdr_flit_t;

  typedef struct packed {
    logic [NOC_W-META_USED-1:0] rsvd;
    tracker_stats_struct        timestamp;
    logic [PROTO_W-1:0]         protocol;
    logic [LEN_W-1:0]           udp_len;
    logic [IP_W-1:0]            dst_ip;
    logic [IP_W-1:0]            src_ip;
  } noc_meta_flit_t;

  // Header flit + metadata flit count as one, then one flit per 64-byte beat.
  function automatic logic [LEN_W:0] exp_msg_len(input logic [LEN_W-1:0] len);
    return (LEN_W+1)'(1) + (((LEN_W+1)'(len) + (LEN_W+1)'(BEAT_BYTES - 1)) >> 6);
  endfunction
endpackage

// File: rtl/udp_tx_noc_in_deser_ctrl.sv
// Packet FSM and valid/ready steering between the NoC port and the two output channels.
module udp_tx_noc_in_deser_ctrl
  import udp_tx_tile_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic noc_val,
  output logic noc_rdy,
  output logic hdr_val,
  input  logic hdr_rdy,
  output logic data_val,
  input  logic data_rdy,
  input  logic beat_last,
  input  logic len_zero,
  output logic in_data,
  output logic hflit_xfer,
  output logic meta_xfer,
  output logic bundle_xfer,
  output logic beat_xfer
);
  deser_state_e state_q, state_d;
  logic         en_q, en_d;

  always_comb begin
    noc_rdy  = 1'b0;
    hdr_val  = 1'b0;
    data_val = 1'b0;
    in_data  = 1'b0;
    case (state_q)
      WAIT_HDR, WAIT_META: noc_rdy = en_q;
      HDR_OUT:             hdr_val = 1'b1;
      DATA_OUT: begin
        in_data  = 1'b1;
        noc_rdy  = data_rdy;
        data_val = noc_val;
      end
      default: ;
    endcase
  end

  assign hflit_xfer  = (state_q == WAIT_HDR)  & noc_val & noc_rdy;
  assign meta_xfer   = (state_q == WAIT_META) & noc_val & noc_rdy;
  assign bundle_xfer = hdr_val & hdr_rdy;
  assign beat_xfer   = data_val & data_rdy;

  always_comb begin
    state_d = state_q;
    // en_q keeps rdy low until the first edge after reset release.
    en_d    = 1'b1;
    case (state_q)
      WAIT_HDR:  if (hflit_xfer)  state_d = WAIT_META;
      WAIT_META: if (meta_xfer)   state_d = HDR_OUT;
      HDR_OUT:   if (bundle_xfer) state_d = len_zero ? WAIT_HDR : DATA_OUT;
      DATA_OUT:  if (beat_xfer && beat_last) state_d = WAIT_HDR;
      default:   state_d = WAIT_HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= WAIT_HDR;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      en_q    <= en_d;
    end
  end
endmodule

// File: rtl/udp_tx_noc_in_deser_datap.sv
// Header/metadata field registers, remaining-byte counter, padbytes and consistency checks.
module udp_tx_noc_in_deser_datap
  import udp_tx_tile_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NOC_W-1:0]    flit,
  input  logic                hflit_xfer,
  input  logic                meta_xfer,
  input  logic                beat_xfer,
  input  logic                in_data,
  output logic [IP_W-1:0]     src_ip,
  output logic [IP_W-1:0]     dst_ip,
  output logic [LEN_W-1:0]    udp_len,
  output logic [PROTO_W-1:0]  protocol,
  output tracker_stats_struct timestamp,
  output logic                beat_last,
  output logic [PAD_W-1:0]    padbytes,
  output logic                len_zero,
  output logic                hdr_err
);
  localparam logic [7:0] MY_X = SRC_X[7:0];
  localparam logic [7:0] MY_Y = SRC_Y[7:0];

  noc_hdr_flit_t  hdr_in;
  noc_meta_flit_t meta_in;
  logic           unused_rsvd;

  assign hdr_in      = noc_hdr_flit_t'(flit);
  assign meta_in     = noc_meta_flit_t'(flit);
  assign unused_rsvd = ^{hdr_in.rsvd, meta_in.rsvd};

  logic [7:0]          dst_x_q, dst_x_d, dst_y_q, dst_y_d;
  logic [15:0]         msg_len_q, msg_len_d;
  logic [IP_W-1:0]     src_ip_q, src_ip_d, dst_ip_q, dst_ip_d;
  logic [LEN_W-1:0]    udp_len_q, udp_len_d, rem_q, rem_d;
  logic [PROTO_W-1:0]  proto_q, proto_d;
  tracker_stats_struct ts_q, ts_d;
  logic                err_q, err_d;

  assign beat_last = in_data & (rem_q <= LEN_W'(BEAT_BYTES));

  always_comb begin
    dst_x_q_next: begin end
    dst_x_d   = dst_x_q;
    dst_y_d   = dst_y_q;
    msg_len_d = msg_len_q;
    src_ip_d  = src_ip_q;
    dst_ip_d  = dst_ip_q;
    udp_len_d = udp_len_q;
    proto_d   = proto_q;
    ts_d      = ts_q;
    rem_d     = rem_q;
    err_d     = 1'b0;
    if (hflit_xfer) begin
      dst_x_d   = hdr_in.dst_x;
      dst_y_d   = hdr_in.dst_y;
      msg_len_d = hdr_in.msg_len;
    end
    if (meta_xfer) begin
      src_ip_d  = meta_in.src_ip;
      dst_ip_d  = meta_in.dst_ip;
      udp_len_d = meta_in.udp_len;
      proto_d   = meta_in.protocol;
      ts_d      = meta_in.timestamp;
      rem_d     = meta_in.udp_len;
      // Mismatch is only flagged; udp_len still drives the beat count.
      err_d     = ({1'b0, msg_len_q} != exp_msg_len(meta_in.udp_len)) ||
                  (dst_x_q != MY_X) || (dst_y_q != MY_Y);
    end
    if (beat_xfer) begin
      rem_d = beat_last ? '0 : rem_q - LEN_W'(BEAT_BYTES);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dst_x_q   <= '0;
      dst_y_q   <= '0;
      msg_len_q <= '0;
      src_ip_q  <= '0;
      dst_ip_q  <= '0;
      udp_len_q <= '0;
      proto_q   <= '0;
      ts_q      <= '0;
      rem_q     <= '0;
      err_q     <= 1'b0;
    end else begin
      dst_x_q   <= dst_x_d;
      dst_y_q   <= dst_y_d;
      msg_len_q <= msg_len_d;
      src_ip_q  <= src_ip_d;
      dst_ip_q  <= dst_ip_d;
      udp_len_q <= udp_len_d;
      proto_q   <= proto_d;
      ts_q      <= ts_d;
      rem_q     <= rem_d;
      err_q     <= err_d;
    end
  end

  assign src_ip    = src_ip_q;
  assign dst_ip    = dst_ip_q;
  assign udp_len   = udp_len_q;
  assign protocol  = proto_q;
  assign timestamp = ts_q;
  assign len_zero  = (udp_len_q == '0);
  assign hdr_err   = err_q;
  // (64 - len mod 64) mod 64 falls out of truncating to the pad width.
  assign padbytes  = beat_last ? PAD_W'(BEAT_BYTES - int'(udp_len_q[5:0])) : '0;
endmodule

// File: rtl/udp_tx_noc_in_deser.sv
// NoC-to-UDP-TX deserializer: header + metadata flits become a header bundle, then data flits pass through.
module udp_tx_noc_in_deser
  import udp_tx_tile_pkg::*;
#(
  parameter int SRC_X = -1,
  parameter int SRC_Y = -1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        noc0_ctovr_udp_tx_in_val,
  input  logic [`NOC_DATA_WIDTH-1:0]  noc0_ctovr_udp_tx_in_data,
  output logic                        udp_tx_in_noc0_ctovr_rdy,
  output logic                        udp_tx_in_hdr_val,
  output logic [`IP_ADDR_W-1:0]       udp_tx_in_src_ip,
  output logic [`IP_ADDR_W-1:0]       udp_tx_in_dst_ip,
  output logic [`TOT_LEN_W-1:0]       udp_tx_in_udp_len,
  output logic [`PROTOCOL_W-1:0]      udp_tx_in_protocol,
  output tracker_stats_struct         udp_tx_in_timestamp,
  input  logic                        udp_tx_in_hdr_rdy,
  output logic                        udp_tx_in_data_val,
  output logic [`MAC_INTERFACE_W-1:0] udp_tx_in_data,
  output logic                        udp_tx_in_data_last,
  output logic [`MAC_PADBYTES_W-1:0]  udp_tx_in_data_padbytes,
  input  logic                        udp_tx_in_data_rdy,
  output logic                        udp_tx_in_hdr_err
);
  logic beat_last, len_zero, in_data;
  logic hflit_xfer, meta_xfer, bundle_xfer, beat_xfer;

  udp_tx_noc_in_deser_ctrl u_ctrl (
    .clk        (clk),
    .rst        (rst),
    .noc_val    (noc0_ctovr_udp_tx_in_val),
    .noc_rdy    (udp_tx_in_noc0_ctovr_rdy),
    .hdr_val    (udp_tx_in_hdr_val),
    .hdr_rdy    (udp_tx_in_hdr_rdy),
    .data_val   (udp_tx_in_data_val),
    .data_rdy   (udp_tx_in_data_rdy),
    .beat_last  (beat_last),
    .len_zero   (len_zero),
    .in_data    (in_data),
    .hflit_xfer (hflit_xfer),
    .meta_xfer  (meta_xfer),
    .bundle_xfer(bundle_xfer),
    .beat_xfer  (beat_xfer)
  );

  udp_tx_noc_in_deser_datap #(
    .SRC_X(SRC_X),
    .SRC_Y(SRC_Y)
  ) u_datap (
    .clk       (clk),
    .rst       (rst),
    .flit      (noc0_ctovr_udp_tx_in_data),
    .hflit_xfer(hflit_xfer),
    .meta_xfer (meta_xfer),
    .beat_xfer (beat_xfer),
    .in_data   (in_data),
    .src_ip    (udp_tx_in_src_ip),
    .dst_ip    (udp_tx_in_dst_ip),
    .udp_len   (udp_tx_in_udp_len),
    .protocol  (udp_tx_in_protocol),
    .timestamp (udp_tx_in_timestamp),
    .beat_last (beat_last),
    .padbytes  (udp_tx_in_data_padbytes),
    .len_zero  (len_zero),
    .hdr_err   (udp_tx_in_hdr_err)
  );

  assign udp_tx_in_data      = MAC_W'(noc0_ctovr_udp_tx_in_data);
  assign udp_tx_in_data_last = beat_last;
endmodule

// File: tb/tb_udp_tx_noc_in_deser.sv
// Randomized bench for udp_tx_noc_in_deser against a packet-level queue model.
module tb_udp_tx_noc_in_deser;
  import udp_tx_tile_pkg::*;

  localparam int MX = 3;
  localparam int MY = 5;
  typedef logic [NOC_W-1:0] wide_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic                in_val, in_rdy, hdr_val, hdr_rdy, data_val, data_rdy, data_last, hdr_err;
  wide_t               in_data;
  logic [IP_W-1:0]     src_ip, dst_ip;
  logic [LEN_W-1:0]    udp_len;
  logic [PROTO_W-1:0]  proto;
  tracker_stats_struct ts;
  logic [MAC_W-1:0]    data;
  logic [PAD_W-1:0]    pad;

  udp_tx_noc_in_deser #(.SRC_X(MX), .SRC_Y(MY)) dut (
    .clk                      (clk),
    .rst                      (rst),
    .noc0_ctovr_udp_tx_in_val (in_val),
    .noc0_ctovr_udp_tx_in_data(in_data),
    .udp_tx_in_noc0_ctovr_rdy (in_rdy),
    .udp_tx_in_hdr_val        (hdr_val),
    .udp_tx_in_src_ip         (src_ip),
    .udp_tx_in_dst_ip         (dst_ip),
    .udp_tx_in_udp_len        (udp_len),
    .udp_tx_in_protocol       (proto),
    .udp_tx_in_timestamp      (ts),
    .udp_tx_in_hdr_rdy        (hdr_rdy),
    .udp_tx_in_data_val       (data_val),
    .udp_tx_in_data           (data),
    .udp_tx_in_data_last      (data_last),
    .udp_tx_in_data_padbytes  (pad),
    .udp_tx_in_data_rdy       (data_rdy),
    .udp_tx_in_hdr_err        (hdr_err)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input wide_t got, input wide_t exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  typedef struct {
    logic [IP_W-1:0]    src, dst;
    logic [LEN_W-1:0]   len;
    logic [PROTO_W-1:0] proto;
    logic [TS_W-1:0]    ts;
    int                 err;
  } hdr_exp_t;

  typedef struct {
    wide_t            data;
    logic             last;
    logic [PAD_W-1:0] pad;
  } beat_exp_t;

  hdr_exp_t  hq[$];
  beat_exp_t bq[$];
  wide_t     fq[$];
  int        rq[$];  // 0 header flit, 1 metadata flit, 2 data flit

  function automatic wide_t rnd_wide();
    wide_t r;
    for (int i = 0; i < NOC_W / 32; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  task automatic add_pkt(input int len, input int msg, input int dx, input int dy);
    noc_hdr_flit_t  h;
    noc_meta_flit_t m;
    hdr_exp_t       e;
    beat_exp_t      b;
    int             n;
    h = '0;
    h.msg_len = 16'(msg);
    h.dst_x   = 8'(dx);
    h.dst_y   = 8'(dy);
    fq.push_back(wide_t'(h));
    rq.push_back(0);
    e.src   = $urandom;
    e.dst   = $urandom;
    e.len   = LEN_W'(len);
    e.proto = PROTO_W'($urandom);
    e.ts    = {$urandom, $urandom};
    n       = (len + 63) / 64;
    e.err   = (msg != 1 + n || dx != MX || dy != MY) ? 1 : 0;
    m = '0;
    m.src_ip       = e.src;
    m.dst_ip       = e.dst;
    m.udp_len      = e.len;
    m.protocol     = e.proto;
    m.timestamp.ts = e.ts;
    fq.push_back(wide_t'(m));
    rq.push_back(1);
    hq.push_back(e);
    for (int i = 0; i < n; i++) begin
      b.data = rnd_wide();
      b.last = (i == n - 1);
      b.pad  = b.last ? PAD_W'((64 - len % 64) % 64) : '0;
      bq.push_back(b);
      fq.push_back(b.data);
      rq.push_back(2);
    end
  endtask

  // mode 0: all ready, 1: random, 2: data_rdy toggles, 3: hdr_rdy held low 5 cycles
  task automatic run(input int mode, input int budget, input int stop_beats);
    int       cyc, hold, errs, beats;
    logic     exp_hv, prev_wait, tog, xfer;
    hdr_exp_t e;
    beat_exp_t b;
    cyc = 0; hold = 0; errs = 0; beats = 0;
    exp_hv = 0; prev_wait = 0; tog = 0;
    while ((fq.size() > 0 || hq.size() > 0 || bq.size() > 0) && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (exp_hv) chk("hdr_latency", wide_t'(hdr_val), wide_t'(1));
      if (prev_wait) chk("hdr_hold", wide_t'(hdr_val), wide_t'(1));
      if (hdr_val) begin
        chk("noc_rdy_in_hdr", wide_t'(in_rdy), wide_t'(0));
        chk("data_val_in_hdr", wide_t'(data_val), wide_t'(0));
      end
      if (hdr_err) begin
        errs++;
        chk("err_with_hdr_val", wide_t'(hdr_val), wide_t'(1));
      end
      xfer   = in_val && in_rdy;
      exp_hv = xfer && rq.size() > 0 && rq[0] == 1;
      prev_wait = hdr_val && !hdr_rdy;
      if (hdr_val && hdr_rdy) begin
        hold = 0;
        if (hq.size() == 0) chk("extra_hdr", wide_t'(1), wide_t'(0));
        else begin
          e = hq.pop_front();
          chk("src_ip", wide_t'(src_ip), wide_t'(e.src));
          chk("dst_ip", wide_t'(dst_ip), wide_t'(e.dst));
          chk("udp_len", wide_t'(udp_len), wide_t'(e.len));
          chk("protocol", wide_t'(proto), wide_t'(e.proto));
          chk("timestamp", wide_t'(ts), wide_t'(e.ts));
          chk("hdr_err_pulses", wide_t'(errs), wide_t'(e.err));
        end
        errs = 0;
      end else if (hdr_val) hold++;
      if (data_val && data_rdy) begin
        beats++;
        if (bq.size() == 0 || hq.size() > 0 && bq.size() > 0 && 0)
          chk("spurious_beat", wide_t'(1), wide_t'(0));
        else begin
          b = bq.pop_front();
          chk("beat_data", wide_t'(data), b.data);
          chk("beat_last", wide_t'(data_last), wide_t'(b.last));
          chk("beat_pad", wide_t'(pad), wide_t'(b.pad));
        end
      end
      @(posedge clk);
      #1;
      if (xfer) begin
        void'(fq.pop_front());
        void'(rq.pop_front());
      end
      in_val  = fq.size() > 0 && (mode != 1 || $urandom_range(3, 0) != 0);
      in_data = fq.size() > 0 ? fq[0] : rnd_wide();
      tog     = ~tog;
      case (mode)
        1:       begin hdr_rdy = 1'($urandom); data_rdy = 1'($urandom); end
        2:       begin hdr_rdy = 1'b1; data_rdy = tog; end
        3:       begin hdr_rdy = (hold >= 5); data_rdy = 1'b1; end
        default: begin hdr_rdy = 1'b1; data_rdy = 1'b1; end
      endcase
      if (stop_beats > 0 && beats >= stop_beats) break;
    end
    if (cyc >= budget) chk("timeout", wide_t'(0), wide_t'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    in_val = 0; in_data = '0; hdr_rdy = 0; data_rdy = 0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_noc_rdy", wide_t'(in_rdy), wide_t'(0));
    chk("rst_hdr_val", wide_t'(hdr_val), wide_t'(0));
    chk("rst_data_val", wide_t'(data_val), wide_t'(0));
    chk("rst_hdr_err", wide_t'(hdr_err), wide_t'(0));
    chk("rst_udp_len", wide_t'(udp_len), wide_t'(0));
    chk("rst_src_ip", wide_t'(src_ip), wide_t'(0));
    rst = 1;
    #1;
    chk("rdy_before_edge", wide_t'(in_rdy), wide_t'(0));
    @(posedge clk);
    #1;
    chk("rdy_after_edge", wide_t'(in_rdy), wide_t'(1));

    add_pkt(100, 3, MX, MY);
    add_pkt(0, 1, MX, MY);
    add_pkt(64, 2, MX, MY);
    add_pkt(1, 2, MX, MY);
    run(0, 200, 0);
    add_pkt(1, 2, MX, MY);
    add_pkt(130, 4, MX, MY);
    run(3, 200, 0);
    add_pkt(200, 5, MX, MY);
    run(2, 200, 0);
    add_pkt(64, 5, MX, MY);
    add_pkt(10, 2, MX + 1, MY);
    add_pkt(70, 3, MX, MY + 2);
    run(0, 200, 0);
    for (int i = 0; i < 24; i++) begin
      int len, msg;
      len = $urandom_range(300, 0);
      msg = 1 + (len + 63) / 64 + (($urandom_range(4, 0) == 0) ? 1 : 0);
      add_pkt(len, msg, ($urandom_range(5, 0) == 0) ? 7 : MX, MY);
    end
    run(1, 6000, 0);

    // Abandon a 3-beat packet during its 2nd beat.
    add_pkt(150, 4, MX, MY);
    run(0, 200, 1);
    rst = 0;
    #1;
    chk("midrst_noc_rdy", wide_t'(in_rdy), wide_t'(0));
    chk("midrst_data_val", wide_t'(data_val), wide_t'(0));
    chk("midrst_hdr_val", wide_t'(hdr_val), wide_t'(0));
    chk("midrst_udp_len", wide_t'(udp_len), wide_t'(0));
    fq.delete(); rq.delete(); hq.delete(); bq.delete();
    in_val = 0;
    @(posedge clk);
    #1;
    rst = 1;
    add_pkt(70, 3, MX, MY);
    in_val  = 1;
    in_data = fq[0];
    run(0, 200, 0);
    chk("hq_empty", wide_t'(hq.size()), wide_t'(0));
    chk("bq_empty", wide_t'(bq.size()), wide_t'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
